// File: rtl/imem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the instruction-fetch port and the
// load/store data port; routes the 1-cycle-latency read data back to the port that issued it.
module imem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction-fetch port
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // Load/store data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // Memory side
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);
  localparam logic       OwnerIf   = 1'b0;
  localparam logic       OwnerD    = 1'b1;

  logic [3:0]            streak_q, streak_d;
  logic                  resp_pend_q, resp_pend_d;
  logic                  resp_owner_q, resp_owner_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  // Word-address slicing drops the byte offset and any bits beyond the memory depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0],
                              d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  always_comb begin
    // D wins unless IF has been waiting through MAX_D_STREAK consecutive D grants.
    d_gnt     = ~rst & d_req & ~(if_req & (streak_q == MaxStreak));
    if_gnt    = ~rst & if_req & ~d_gnt;
    mem_en    = if_gnt | d_gnt;
    mem_we    = (d_gnt & d_we) ? d_be : 4'b0000;
    mem_addr  = d_gnt ? d_addr[ADDR_WIDTH+1:2] : if_addr[ADDR_WIDTH+1:2];
    mem_wdata = d_wdata;

    // An in-flight response is dropped while reset is asserted.
    if_rvalid = ~rst & resp_pend_q & (resp_owner_q == OwnerIf);
    d_rvalid  = ~rst & resp_pend_q & (resp_owner_q == OwnerD);
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = 4'd0;
    end else if (d_gnt && (streak_q < MaxStreak)) begin
      streak_d = streak_q + 4'd1;
    end

    resp_pend_d  = if_gnt | (d_gnt & ~d_we);
    resp_owner_d = d_gnt ? OwnerD : OwnerIf;
    if_rdata_d   = if_rdata;
    d_rdata_d    = d_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q     <= 4'd0;
      resp_pend_q  <= 1'b0;
      resp_owner_q <= OwnerIf;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      streak_q     <= streak_d;
      resp_pend_q  <= resp_pend_d;
      resp_owner_q <= resp_owner_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: directed scenarios followed by randomized traffic,
// checked against a rule-level reference model and a behavioural memory.
module tb_imem_port_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int MAXS  = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [31:0]   if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]    d_be;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Behavioural block RAM driven by the DUT, and the bench's own reference copy.
  logic [DW-1:0] env_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = DW'(i) ^ (DW'(i) << 20) ^ 32'h5A00_0000;
      ref_mem[i] = env_mem[i];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we == 4'b0000) mem_rdata <= env_mem[mem_addr];
    else mem_rdata <= DW'($urandom);
    if (mem_en && mem_we != 4'b0000) env_mem[mem_addr] <= merge(env_mem[mem_addr], mem_wdata, mem_we);
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;
  resp_t q_if[$];
  resp_t q_d[$];

  // Reference model: count of D grants in a row while IF keeps waiting.
  int d_run = 0;

  always @(negedge clk) begin : grant_chk
    logic          e_if, e_d;
    logic [AW-1:0] a;
    if (rst) begin
      e_if = 1'b0;
      e_d  = 1'b0;
    end else begin
      e_d  = d_req && !(if_req && d_run >= MAXS);
      e_if = if_req && !e_d;
    end
    chk("if_gnt", if_gnt, e_if);
    chk("d_gnt", d_gnt, e_d);
    chk("mem_en", mem_en, e_if | e_d);
    chk("mem_we", mem_we, (e_d && d_we) ? d_be : 4'b0000);
    if (e_if) begin
      a = if_addr[AW+1:2];
      chk("if_mem_addr", mem_addr, a);
      q_if.push_back('{due: cyc + 1, data: ref_mem[a]});
    end
    if (e_d) begin
      a = d_addr[AW+1:2];
      chk("d_mem_addr", mem_addr, a);
      if (d_we) begin
        chk("mem_wdata", mem_wdata, d_wdata);
        ref_mem[a] = merge(ref_mem[a], d_wdata, d_be);
      end else begin
        q_d.push_back('{due: cyc + 1, data: ref_mem[a]});
      end
    end
    if (rst || !if_req || e_if) d_run = 0;
    else if (e_d) d_run++;
  end

  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_d  = '0;

  always @(negedge clk) begin : monitor
    logic exp_v;
    if (rst) begin
      q_if.delete();
      q_d.delete();
      chk("if_rvalid_rst", if_rvalid, 1'b0);
      chk("d_rvalid_rst", d_rvalid, 1'b0);
      last_if = '0;
      last_d  = '0;
    end else begin
      exp_v = (q_if.size() > 0) && (q_if[0].due == cyc);
      chk("if_rvalid", if_rvalid, exp_v);
      if (exp_v) begin
        chk("if_rdata", if_rdata, q_if[0].data);
        last_if = q_if[0].data;
        void'(q_if.pop_front());
      end else begin
        chk("if_rdata_hold", if_rdata, last_if);
      end
      exp_v = (q_d.size() > 0) && (q_d[0].due == cyc);
      chk("d_rvalid", d_rvalid, exp_v);
      if (exp_v) begin
        chk("d_rdata", d_rdata, q_d[0].data);
        last_d = q_d[0].data;
        void'(q_d.pop_front());
      end else begin
        chk("d_rdata_hold", d_rdata, last_d);
      end
    end
  end

  logic          g_if, g_d;
  logic [3:0]    g_we;
  logic [AW-1:0] g_addr;

  // Sample this cycle's grant, then apply the next cycle's stimulus just after the edge.
  task automatic step();
    @(negedge clk);
    g_if   = if_gnt;
    g_d    = d_gnt;
    g_we   = mem_we;
    g_addr = mem_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    string pat;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // IF-only stream of consecutive words
    for (int i = 0; i < 3; i++) begin
      if_req  = 1'b1;
      if_addr = 32'(i * 4);
      step();
      chk("t1_if_gnt", g_if, 1'b1);
    end
    if_req = 1'b0;
    step();

    // D read beats a simultaneous IF request
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    step();
    chk("t2_d_gnt", g_d, 1'b1);
    chk("t2_if_gnt", g_if, 1'b0);
    chk("t2_mem_addr", g_addr, 12'h040);
    d_req = 1'b0;
    step();
    chk("t2_if_later", g_if, 1'b1);
    if_req = 1'b0;
    step();

    // Starvation guard with both ports held busy
    pat = "";
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      step();
      pat = {pat, g_d ? "D" : (g_if ? "I" : "-")};
      if (g_if) if_addr = if_addr + 32'd4;
    end
    n_chk++;
    if (pat != "DDDDIDDD") begin
      n_fail++;
      $display("FAIL t3_pattern: got %s expected DDDDIDDD", pat);
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Partial write then read-back of the same word
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    step();
    chk("t4_d_gnt", g_d, 1'b1);
    chk("t4_mem_we", g_we, 4'b0011);
    chk("t4_mem_addr", g_addr, 12'd2);
    d_we = 1'b0; d_be = 4'b0000;
    step();
    chk("t4_rd_gnt", g_d, 1'b1);
    d_req = 1'b0;
    step();

    // Address wraps modulo depth
    if_req = 1'b1; if_addr = 32'h4004;
    step();
    chk("t5_mem_addr", g_addr, 12'd1);
    if_req = 1'b0;
    step();

    // Reset arriving while a D read response is in flight
    d_req = 1'b1; d_addr = 32'h10;
    step();
    chk("t6_d_gnt", g_d, 1'b1);
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h30;
    repeat (2) begin
      step();
      chk("t6_no_d_gnt", g_d, 1'b0);
      chk("t6_no_if_gnt", g_if, 1'b0);
    end
    rst = 1'b0; d_req = 1'b0;
    step();
    chk("t6_if_after", g_if, 1'b1);
    if_req = 1'b0;
    step();

    // Randomized traffic: pending requests are usually held, occasionally dropped
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!(if_req && !g_if) || $urandom_range(0, 15) == 0) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'hF000_C0FF;
      end
      if (!(d_req && !g_d) || $urandom_range(0, 15) == 0) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_be    = 4'($urandom);
        d_addr  = $urandom & 32'hF000_C0FF;
        d_wdata = $urandom;
      end
      step();
    end

    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (3) step();
    chk("drain_empty", 64'(q_if.size() + q_d.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
